// File: rtl/lfsr_encrypt_stage_pkg.sv
// Shared constants, state type and LFSR helpers for the 6-bit LFSR encrypt stage.
package lfsr_encrypt_stage_pkg;

    localparam int unsigned MSG_LEN  = 64;
    localparam logic [7:0]  PT_BASE  = 8'd0;
    localparam logic [7:0]  CT_BASE  = 8'd64;
    localparam logic [7:0]  PRE_CHAR = 8'h5F;
    localparam logic [3:0]  PRE_MIN  = 4'd7;
    localparam logic [3:0]  PRE_MAX  = 4'd12;
    localparam logic [2:0]  TAP_MAX  = 3'd5;

    localparam logic [5:0] TAPS [6] = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};

    typedef enum logic [1:0] {IDLE, LOAD, ENC, DONE} enc_state_t;

    function automatic logic [5:0] lfsr_next(input logic [5:0] state, input logic [5:0] taps);
        return {state[4:0], ^(state & taps)};
    endfunction

    // Out-of-range selects return 0; they are rejected before ever reaching ENC.
    function automatic logic [5:0] tap_mask(input logic [2:0] sel);
        logic [5:0] m;
        m = 6'h00;
        for (int i = 0; i < 6; i++) begin
            if (sel == 3'(i)) m = TAPS[i];
        end
        return m;
    endfunction

    function automatic logic [3:0] clamp_pre(input logic [3:0] len);
        if (len < PRE_MIN) return PRE_MIN;
        if (len > PRE_MAX) return PRE_MAX;
        return len;
    endfunction

endpackage

// File: rtl/lfsr_encrypt_stage_if.sv
// Run control and dat_mem port bundle between the host/memory side and the encrypter.
interface lfsr_encrypt_stage_if;

    logic       start;
    logic [2:0] tap_sel;
    logic [5:0] seed;
    logic [3:0] pre_len;
    logic [7:0] rd_data;
    logic [7:0] raddr;
    logic [7:0] waddr;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, tap_sel, seed, pre_len, rd_data,
        input  raddr, waddr, wr_en, wr_data, busy, done, err
    );

    modport slave (
        input  start, tap_sel, seed, pre_len, rd_data,
        output raddr, waddr, wr_en, wr_data, busy, done, err
    );

endinterface

// File: rtl/lfsr_encrypt_stage_lfsr6.sv
// 6-bit Fibonacci LFSR: loads start on init, shifts left with tap parity on en.
module lfsr6
    import lfsr_encrypt_stage_pkg::*;
(
    input  logic       clk,
    input  logic       en,
    input  logic       init,
    input  logic [5:0] taps,
    input  logic [5:0] start,
    output logic [5:0] state
);

    always_ff @(posedge clk) begin
        if (init) begin
            state <= start;
        end else if (en) begin
            state <= lfsr_next(state, taps);
        end
    end

endmodule

// File: rtl/lfsr_encrypt_stage.sv
// Encrypter: preamble + plaintext low 6 bits XOR LFSR stream, written to dat_mem[64..127].
module lfsr_encrypt_stage
    import lfsr_encrypt_stage_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 init_i,
    lfsr_encrypt_stage_if.slave  bus
);

    enc_state_t state_q, state_d;
    logic [6:0] k_q, k_d;
    logic [2:0] tap_q, tap_d;
    logic [5:0] seed_q, seed_d;
    logic [3:0] pre_q, pre_d;
    logic       err_q, err_d;

    logic       in_enc;
    logic       in_pre;
    logic [5:0] lfsr_s;
    logic [7:0] plain;
    logic [7:0] pt_off;

    always_ff @(posedge clk_i) begin
        if (init_i) begin
            state_q <= IDLE;
            k_q     <= '0;
            tap_q   <= '0;
            seed_q  <= '0;
            pre_q   <= PRE_MIN;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            tap_q   <= tap_d;
            seed_q  <= seed_d;
            pre_q   <= pre_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        tap_d   = tap_q;
        seed_d  = seed_q;
        pre_d   = pre_q;
        err_d   = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    tap_d  = bus.tap_sel;
                    seed_d = bus.seed;
                    pre_d  = clamp_pre(bus.pre_len);
                    // A rejected start also drops done by parking in IDLE.
                    if ((bus.tap_sel > TAP_MAX) || (bus.seed == 6'd0)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                k_d     = '0;
                state_d = ENC;
            end
            ENC: begin
                k_d = k_q + 7'd1;
                if (k_q == 7'(MSG_LEN - 1)) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_enc = (state_q == ENC);
    assign in_pre = (k_q < {3'b000, pre_q});

    lfsr6 u_lfsr (
        .clk   (clk_i),
        .en    (in_enc && !init_i),
        .init  (state_q == LOAD),
        .taps  (tap_mask(tap_q)),
        .start (seed_q),
        .state (lfsr_s)
    );

    assign pt_off      = {1'b0, k_q} - {4'b0000, pre_q};
    assign plain       = in_pre ? PRE_CHAR : bus.rd_data;
    assign bus.raddr   = (in_enc && !in_pre) ? (PT_BASE + pt_off) : 8'd0;
    assign bus.waddr   = in_enc ? (CT_BASE + {1'b0, k_q}) : 8'd0;
    assign bus.wr_en   = in_enc && !init_i;
    assign bus.wr_data = in_enc ? {2'b00, plain[5:0] ^ lfsr_s} : 8'd0;
    assign bus.busy    = (state_q == LOAD) || (state_q == ENC);
    assign bus.done    = (state_q == DONE);
    assign bus.err     = err_q;

endmodule
